// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master turning a cmd/rsp port into AXI4-Lite reads and writes.
module axi4_lite_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);
  typedef enum logic [2:0] {S_IDLE, S_WADDR_DATA, S_WRESP, S_RADDR, S_RDATA, S_RESP} state_t;
  state_t                    r_state, w_next;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic [1:0]                r_resp;
  logic                      r_aw_done, r_w_done;
  logic                      w_aw_hs, w_w_hs;
  // Every output is a decode of registered state; no AXI input reaches an AXI output.
  assign cmd_ready     = r_state == S_IDLE;
  assign rsp_valid     = r_state == S_RESP;
  assign M_AXI_AWVALID = (r_state == S_WADDR_DATA) && !r_aw_done;
  assign M_AXI_WVALID  = (r_state == S_WADDR_DATA) && !r_w_done;
  assign M_AXI_BREADY  = r_state == S_WRESP;
  assign M_AXI_ARVALID = r_state == S_RADDR;
  assign M_AXI_RREADY  = r_state == S_RDATA;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign w_aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs        = M_AXI_WVALID && M_AXI_WREADY;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = cmd_valid ? (cmd_write ? S_WADDR_DATA : S_RADDR) : S_IDLE;
      S_WADDR_DATA: w_next = ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) ? S_WRESP : S_WADDR_DATA;
      S_WRESP:      w_next = M_AXI_BVALID ? S_RESP : S_WRESP;
      S_RADDR:      w_next = M_AXI_ARREADY ? S_RDATA : S_RADDR;
      S_RDATA:      w_next = M_AXI_RVALID ? S_RESP : S_RDATA;
      S_RESP:       w_next = rsp_ready ? S_IDLE : S_RESP;
      default:      w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cmd_valid) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) r_w_done <= 1'b1;
      if (r_state == S_WRESP && M_AXI_BVALID) begin
        r_resp  <= M_AXI_BRESP;
        r_rdata <= '0;
      end
      if (r_state == S_RDATA && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed scenarios with hand-computed expectations for axi4_lite_master.
module tb_axi4_lite_master;
  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [1:0]  bresp = 0, rresp = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic [31:0] rdata = 0;
  int checks = 0, errors = 0;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic consume();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL consume_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL consume_rsp_valid: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin errors++; $display("FAIL rst_handshakes: got %b exp 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
    checks++; if ({awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp} !== '0) begin errors++; $display("FAIL rst_data: awaddr %h wdata %h wstrb %h rdata %h resp %b exp all 0", awaddr, wdata, wstrb, rsp_rdata, rsp_resp); end
    ARESETN = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    awready = 0; wready = 0;
    tick();
    cmd_valid = 0;
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL mid_pre_valids: got %b exp 11", {awvalid, wvalid}); end
    #2 ARESETN = 0;
    #1;
    checks++; if ({awvalid, wvalid} !== 2'b00) begin errors++; $display("FAIL mid_async_valids: got %b exp 00", {awvalid, wvalid}); end
    checks++; if (awaddr !== 32'h0 || wdata !== 32'h0) begin errors++; $display("FAIL mid_async_data: awaddr %h wdata %h exp 0", awaddr, wdata); end
    tick();
    ARESETN = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release: cmd_ready %b rsp_valid %b exp 1 0", cmd_ready, rsp_valid); end
    end
  endtask

  task automatic test_write_basic();
    awready = 1; wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 0; cmd_wdata = 32'h0;
    checks++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin errors++; $display("FAIL wr_valids: got %b exp 110", {awvalid, wvalid, cmd_ready}); end
    checks++; if (awaddr !== 32'h4 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin errors++; $display("FAIL wr_bus: awaddr %h wdata %h wstrb %h exp 4 deadbeef f", awaddr, wdata, wstrb); end
    tick();
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_after_hs: got %b exp 001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: valid %b resp %b rdata %h exp 1 00 0", rsp_valid, rsp_resp, rsp_rdata); end
    consume();
  endtask

  task automatic test_write_wdelay();
    awready = 1; wready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (awvalid !== (i == 0) || wvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL wd_cycle%0d: aw %b w %b b %b exp %b 1 0", i, awvalid, wvalid, bready, i == 0); end
      checks++; if (wdata !== 32'h12345678 || wstrb !== 4'h3) begin errors++; $display("FAIL wd_stable%0d: wdata %h wstrb %h exp 12345678 3", i, wdata, wstrb); end
      if (i == 3) wready = 1;
      tick();
    end
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wd_bready: got %b exp 001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b11;
    tick();
    bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11) begin errors++; $display("FAIL wd_rsp: valid %b resp %b exp 1 11", rsp_valid, rsp_resp); end
    consume();
    tick();
    checks++; if (rsp_valid !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL wd_single: rsp_valid %b awvalid %b exp 0 0", rsp_valid, awvalid); end
  endtask

  task automatic test_write_awdelay();
    awready = 0; wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'h8;
    tick();
    cmd_valid = 0;
    tick();
    checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL ad_wfirst: got %b exp 100", {awvalid, wvalid, bready}); end
    checks++; if (awaddr !== 32'hC) begin errors++; $display("FAIL ad_awaddr: got %h exp c", awaddr); end
    awready = 1;
    tick();
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL ad_both: got %b exp 001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0;
    checks++; if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL ad_rsp: resp %b rdata %h exp 10 0", rsp_resp, rsp_rdata); end
    consume();
  endtask

  task automatic test_read();
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
    tick();
    cmd_valid = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h4 || awvalid !== 1'b0) begin errors++; $display("FAIL rd_ar: arvalid %b araddr %h awvalid %b exp 1 4 0", arvalid, araddr, awvalid); end
    tick();
    checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL rd_rready: arvalid %b rready %b exp 0 1", arvalid, rready); end
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin errors++; $display("FAIL rd_rsp: valid %b rdata %h resp %b exp 1 deadbeef 00", rsp_valid, rsp_rdata, rsp_resp); end
    consume();
  endtask

  task automatic test_read_backpressure();
    arready = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    tick();
    cmd_valid = 0;
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h20) begin errors++; $display("FAIL bp_ar_hold: arvalid %b araddr %h exp 1 20", arvalid, araddr); end
    arready = 1;
    tick();
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
    tick();
    rvalid = 0; rdata = 32'h0; rresp = 2'b00;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h99;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'hCAFEF00D || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: valid %b resp %b rdata %h cmd_ready %b exp 1 10 cafef00d 0", i, rsp_valid, rsp_resp, rsp_rdata, cmd_ready); end
      tick();
    end
    cmd_valid = 0;
    consume();
  endtask

  task automatic test_back_to_back();
    awready = 1; wready = 1; arready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    tick();
    cmd_write = 0; cmd_addr = 32'h24;
    tick();
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL b2b_first_rsp: rsp_valid %b cmd_ready %b arvalid %b exp 1 0 0", rsp_valid, cmd_ready, arvalid); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++; if (cmd_ready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: cmd_ready %b arvalid %b exp 1 0", cmd_ready, arvalid); end
    tick();
    cmd_valid = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h24 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second: arvalid %b araddr %h cmd_ready %b exp 1 24 0", arvalid, araddr, cmd_ready); end
    tick();
    rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b01;
    tick();
    rvalid = 0;
    checks++; if (rsp_rdata !== 32'h0BADF00D || rsp_resp !== 2'b01) begin errors++; $display("FAIL b2b_rd_rsp: rdata %h resp %b exp 0badf00d 01", rsp_rdata, rsp_resp); end
    consume();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_basic();
    test_write_wdelay();
    test_write_awdelay();
    test_read();
    test_read_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
